// File: rtl/alu_issue_ctrl.sv
// Issue/return controller for the 8-bit ALU: command FIFO, fixed-latency issue pipe, credit-limited response FIFO.
// Optional stat_issued/stat_stall counters are built when ALU_ISSUE_STATS_EN is defined.
`timescale 1ns/1ps
module alu_issue_ctrl #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TAG_W     = 4,
   parameter int ALU_LAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef ALU_ISSUE_STATS_EN
   output logic [15:0]      stat_issued,
   output logic [15:0]      stat_stall,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [2:0]       cmd_op,
   input  logic [2:0]       cmd_shamt,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_op,
   output logic [2:0]       alu_shift,
   input  logic [7:0]       alu_result,
   input  logic [7:0]       alu_barrel_a,
   input  logic [7:0]       alu_barrel_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic [7:0]       rsp_aux,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_overflow
);
   localparam int CPW = $clog2(CMD_DEPTH);
   localparam int RPW = $clog2(RSP_DEPTH);
   localparam logic [CPW:0] CMD_FULL = CMD_DEPTH[CPW:0];
   localparam logic [7:0]   RSP_CAP  = RSP_DEPTH[7:0];
   localparam logic [2:0]   OP_ADD = 3'd0;
   localparam logic [2:0]   OP_SUB = 3'd3;
   localparam logic [2:0]   OP_BAR = 3'd7;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [2:0]       op;
      logic [2:0]       shamt;
      logic [7:0]       a;
      logic [7:0]       b;
   } cmd_t;

   typedef struct packed {
      logic [7:0]       result;
      logic [7:0]       aux;
      logic [TAG_W-1:0] tag;
      logic             zero;
      logic             carry;
      logic             ovf;
   } rsp_t;

   // ---------------- command FIFO ----------------
   cmd_t           cmd_mem [CMD_DEPTH];
   logic [CPW-1:0] cmd_wptr, cmd_rptr;
   logic [CPW:0]   cmd_count;
   cmd_t           cmd_in, cmd_head;
   logic           cmd_push, issue, credit_ok;

   assign cmd_ready = (cmd_count != CMD_FULL);
   assign cmd_push  = cmd_valid && cmd_ready;
   assign cmd_in    = '{tag: cmd_tag, op: cmd_op, shamt: cmd_shamt, a: cmd_a, b: cmd_b};
   assign cmd_head  = cmd_mem[cmd_rptr];

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wptr] <= cmd_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_wptr  <= '0;
         cmd_rptr  <= '0;
         cmd_count <= '0;
      end else begin
         if (cmd_push) cmd_wptr <= cmd_wptr + 1'b1;
         if (issue)    cmd_rptr <= cmd_rptr + 1'b1;
         case ({cmd_push, issue})
            2'b10:   cmd_count <= cmd_count + 1'b1;
            2'b01:   cmd_count <= cmd_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- issue pipe ----------------
   logic             pipe_vld [ALU_LAT+1];
   logic [TAG_W-1:0] pipe_tag [ALU_LAT+1];
   logic [2:0]       pipe_op  [ALU_LAT+1];
   logic [7:0]       pipe_a   [ALU_LAT+1];
   logic [7:0]       pipe_b   [ALU_LAT+1];
   logic [7:0]       inflight;
   logic [RPW:0]     rsp_count;

   // Every op in the pipe already owns a response slot, so capture can never overflow.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= ALU_LAT; i++) inflight = inflight + 8'(pipe_vld[i]);
   end

   assign credit_ok = (8'(rsp_count) + inflight) < RSP_CAP;
   assign issue     = (cmd_count != '0) && credit_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         alu_shift <= '0;
      end else if (issue) begin
         alu_a     <= cmd_head.a;
         alu_b     <= cmd_head.b;
         alu_op    <= cmd_head.op;
         alu_shift <= cmd_head.shamt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= ALU_LAT; i++) begin
            pipe_vld[i] <= 1'b0;
            pipe_tag[i] <= '0;
            pipe_op[i]  <= '0;
            pipe_a[i]   <= '0;
            pipe_b[i]   <= '0;
         end
      end else begin
         pipe_vld[0] <= issue;
         if (issue) begin
            pipe_tag[0] <= cmd_head.tag;
            pipe_op[0]  <= cmd_head.op;
            pipe_a[0]   <= cmd_head.a;
            pipe_b[0]   <= cmd_head.b;
         end
         for (int i = 1; i <= ALU_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
            pipe_op[i]  <= pipe_op[i-1];
            pipe_a[i]   <= pipe_a[i-1];
            pipe_b[i]   <= pipe_b[i-1];
         end
      end
   end

   // ---------------- capture and flags ----------------
   logic       cap;
   logic [7:0] ta, tb;
   logic [2:0] top;
   logic [8:0] sum9;
   rsp_t       cap_rsp;

   assign cap  = pipe_vld[ALU_LAT];
   assign ta   = pipe_a[ALU_LAT];
   assign tb   = pipe_b[ALU_LAT];
   assign top  = pipe_op[ALU_LAT];
   assign sum9 = {1'b0, ta} + {1'b0, tb};

   always_comb begin
      cap_rsp     = '0;
      cap_rsp.tag = pipe_tag[ALU_LAT];
      if (top == OP_BAR) begin
         cap_rsp.result = alu_barrel_a;
         cap_rsp.aux    = alu_barrel_b;
      end else begin
         cap_rsp.result = alu_result;
      end
      case (top)
         OP_ADD: begin
            cap_rsp.carry = sum9[8];
            cap_rsp.ovf   = (ta[7] == tb[7]) && (cap_rsp.result[7] != ta[7]);
         end
         OP_SUB: begin
            cap_rsp.carry = (ta < tb);
            cap_rsp.ovf   = (ta[7] != tb[7]) && (cap_rsp.result[7] != ta[7]);
         end
         default: ;
      endcase
      cap_rsp.zero = (cap_rsp.result == 8'h00);
   end

   // ---------------- response FIFO ----------------
   rsp_t           rsp_mem [RSP_DEPTH];
   logic [RPW-1:0] rsp_wptr, rsp_rptr;
   logic           rsp_pop;
   rsp_t           rsp_head;

   assign rsp_valid = (rsp_count != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;
   // Head is masked while empty so idle outputs read as zero rather than stale entries.
   assign rsp_head  = rsp_valid ? rsp_mem[rsp_rptr] : '0;

   assign rsp_result   = rsp_head.result;
   assign rsp_aux      = rsp_head.aux;
   assign rsp_tag      = rsp_head.tag;
   assign rsp_zero     = rsp_head.zero;
   assign rsp_carry    = rsp_head.carry;
   assign rsp_overflow = rsp_head.ovf;

   always_ff @(posedge clk) begin
      if (cap) rsp_mem[rsp_wptr] <= cap_rsp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_wptr  <= '0;
         rsp_rptr  <= '0;
         rsp_count <= '0;
      end else begin
         if (cap)     rsp_wptr <= rsp_wptr + 1'b1;
         if (rsp_pop) rsp_rptr <= rsp_rptr + 1'b1;
         case ({cap, rsp_pop})
            2'b10:   rsp_count <= rsp_count + 1'b1;
            2'b01:   rsp_count <= rsp_count - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   logic stall_now;
   assign stall_now = (cmd_count != '0) && !credit_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (issue && stat_issued != 16'hFFFF)    stat_issued <= stat_issued + 16'd1;
         if (stall_now && stat_stall != 16'hFFFF) stat_stall  <= stat_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a one-cycle registered ALU model.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
   localparam int TAG_W  = 4;
   localparam int BUDGET = 200;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [7:0]       cmd_a = '0, cmd_b = '0;
   logic [2:0]       cmd_op = '0, cmd_shamt = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic [7:0]       alu_a, alu_b;
   logic [2:0]       alu_op, alu_shift;
   logic [7:0]       alu_result = '0, alu_barrel_a = '0, alu_barrel_b = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [7:0]       rsp_result, rsp_aux;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_zero, rsp_carry, rsp_overflow;
`ifdef ALU_ISSUE_STATS_EN
   logic [15:0]      stat_issued, stat_stall;
`endif

   alu_issue_ctrl dut (
`ifdef ALU_ISSUE_STATS_EN
      .stat_issued (stat_issued),
      .stat_stall  (stat_stall),
`endif
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_op       (cmd_op),
      .cmd_shamt    (cmd_shamt),
      .cmd_tag      (cmd_tag),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_shift    (alu_shift),
      .alu_result   (alu_result),
      .alu_barrel_a (alu_barrel_a),
      .alu_barrel_b (alu_barrel_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_aux      (rsp_aux),
      .rsp_tag      (rsp_tag),
      .rsp_zero     (rsp_zero),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]       result;
      logic [7:0]       aux;
      logic [TAG_W-1:0] tag;
      logic             zero;
      logic             carry;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0, bad = 0;
   int   accepted = 0;
   int   cyc = 0, last_pop_cyc = 0, prev_pop_cyc = 0;
   bit   rand_done = 0;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd0: return a + b;
         3'd1: return a & b;
         3'd2: return a | b;
         3'd3: return a - b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
         3'd6: return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   // ALU environment: registered, one edge of latency.
   always @(posedge clk) begin
      cyc          <= cyc + 1;
      alu_result   <= alu_fn(alu_a, alu_b, alu_op);
      alu_barrel_a <= alu_a << alu_shift;
      alu_barrel_b <= alu_b << alu_shift;
   end

   function automatic exp_t expect_of(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                      input logic [2:0] sh, input logic [TAG_W-1:0] tag);
      exp_t e;
      int   ua, ub, sa, sb;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      e = '0;
      e.tag = tag;
      if (op == 3'd7) begin
         e.result = a << sh;
         e.aux    = b << sh;
      end else begin
         e.result = alu_fn(a, b, op);
      end
      if (op == 3'd0) begin
         e.carry = (ua + ub) > 255;
         e.ovf   = ((sa + sb) > 127) || ((sa + sb) < -128);
      end else if (op == 3'd3) begin
         e.carry = ua < ub;
         e.ovf   = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      e.zero = (e.result == 8'h00);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e.result));
            chk("rsp_aux", 32'(rsp_aux), 32'(e.aux));
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            chk("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
         end
      end
   end

   // Offer one command; returns 1 tick after the accepting edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [2:0] sh, input logic [TAG_W-1:0] tag);
      int n = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_shamt = sh; cmd_tag = tag;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(expect_of(a, b, op, sh, tag));
      accepted++;
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < BUDGET) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, base, stale;
      #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      pulse_reset();

      // ADD overflow and latency from acceptance to rsp_valid
      rsp_ready = 1'b1;
      send(8'h7F, 8'h01, 3'd0, 3'd0, 4'd3);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!rsp_valid && n < 20);
      chk("add_latency", 32'(n), 32'd3);
      drain();

      // Back-to-back SUBs must return on consecutive cycles
      send(8'h05, 8'h05, 3'd3, 3'd0, 4'd1);
      send(8'h03, 8'h05, 3'd3, 3'd0, 4'd2);
      drain();
      chk("sub_consecutive", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);

      send(8'h81, 8'h03, 3'd7, 3'd1, 4'd4);
      drain();

      // Random mix with a wandering consumer
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++)
               send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 4'(i));
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 rsp_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rsp_ready = 1'b1;
      drain();

      // Backpressure: 4 in the command FIFO plus 4 credited slots downstream
      pulse_reset();
      rsp_ready = 1'b0;
      base = accepted;
      fork
         begin
            for (int i = 0; i < 10; i++) send(8'(i), 8'(i + 1), 3'd0, 3'd0, 4'(i));
         end
         begin
            repeat (20) @(posedge clk);
            #2;
            chk("bp_accepted", 32'(accepted - base), 32'd8);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            rsp_ready = 1'b1;
         end
      join
      drain();
      chk("bp_total_accepted", 32'(accepted - base), 32'd10);
`ifdef ALU_ISSUE_STATS_EN
      chk("stat_issued", 32'(stat_issued), 32'd10);
      chk("stat_stall_nonzero", 32'(stat_stall != 16'd0), 32'd1);
`endif

      // Reset with two ops in flight and one response queued
      rsp_ready = 1'b0;
      send(8'h11, 8'h22, 3'd2, 3'd5, 4'd9);
      send(8'h33, 8'h44, 3'd2, 3'd6, 4'd10);
      send(8'h55, 8'h66, 3'd2, 3'd7, 4'd11);
      @(posedge clk);
      #2;
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_regs", {alu_a, alu_b, 5'd0, alu_op, 5'd0, alu_shift}, 32'd0);
      chk("rst_rsp_data", {rsp_result, rsp_aux, 4'd0, rsp_tag, 5'd0, rsp_zero, rsp_carry, rsp_overflow}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) stale++;
      end
      chk("no_stale_rsp", 32'(stale), 32'd0);
      @(posedge clk);
      #1;
      send(8'h01, 8'h01, 3'd0, 3'd0, 4'd5);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
